// File: rtl/pipe_reg_elastic.sv
// Cascade of DEPTH elastic pipeline stages, each a main register plus a skid register.
// Upstream ready is a register; hold freezes everything and flush empties every stage.
module pipe_reg_elastic #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16,
    parameter int DEPTH  = 1
) (
    input  logic                             Clk,
    input  logic                             Reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_W-1:0]                in_data,
    input  logic [CTRL_W-1:0]                in_ctrl,
    input  logic                             hold,
    input  logic                             flush,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_W-1:0]                out_data,
    output logic [CTRL_W-1:0]                out_ctrl,
    output logic [$clog2(2*DEPTH+1)-1:0]     count
);

    localparam int COUNT_W = $clog2(2*DEPTH+1);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [DEPTH-1:0]  stage_valid;
    logic [DEPTH-1:0]  stage_ready;
    logic [DATA_W-1:0] stage_data [DEPTH];
    logic [CTRL_W-1:0] stage_ctrl [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic              up_valid;
        logic [DATA_W-1:0] up_data;
        logic [CTRL_W-1:0] up_ctrl;
        logic              dn_ready;
        logic              push;
        logic              pop;
        logic [1:0]        state_reg;
        logic              ready_reg;
        logic [DATA_W-1:0] main_data_reg;
        logic [DATA_W-1:0] skid_data_reg;
        logic [CTRL_W-1:0] main_ctrl_reg;
        logic [CTRL_W-1:0] skid_ctrl_reg;

        if (gi == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_data  = in_data;
            assign up_ctrl  = in_ctrl;
        end else begin : g_link
            assign up_valid = stage_valid[gi-1];
            assign up_data  = stage_data[gi-1];
            assign up_ctrl  = stage_ctrl[gi-1];
        end

        if (gi == DEPTH-1) begin : g_tail
            assign dn_ready = out_ready;
        end else begin : g_next
            assign dn_ready = stage_ready[gi+1];
        end

        // The upstream stage's pop and this stage's push are the same expression.
        assign push = up_valid & ready_reg & ~hold;
        assign pop  = (state_reg != ST_EMPTY) & dn_ready & ~hold;

        always_ff @(posedge Clk or negedge Reset) begin
            if (!Reset) begin
                state_reg     <= ST_EMPTY;
                ready_reg     <= 1'b1;
                main_data_reg <= '0;
                skid_data_reg <= '0;
                main_ctrl_reg <= '0;
                skid_ctrl_reg <= '0;
            end else if (flush) begin
                state_reg     <= ST_EMPTY;
                ready_reg     <= 1'b1;
                main_data_reg <= '0;
                skid_data_reg <= '0;
                main_ctrl_reg <= '0;
                skid_ctrl_reg <= '0;
            end else if (!hold) begin
                case (state_reg)
                    ST_EMPTY: begin
                        if (push) begin
                            state_reg     <= ST_ONE;
                            main_data_reg <= up_data;
                            main_ctrl_reg <= up_ctrl;
                        end
                    end
                    ST_ONE: begin
                        if (push && pop) begin
                            main_data_reg <= up_data;
                            main_ctrl_reg <= up_ctrl;
                        end else if (push) begin
                            state_reg     <= ST_TWO;
                            ready_reg     <= 1'b0;
                            skid_data_reg <= up_data;
                            skid_ctrl_reg <= up_ctrl;
                        end else if (pop) begin
                            state_reg     <= ST_EMPTY;
                            main_data_reg <= '0;
                            main_ctrl_reg <= '0;
                        end
                    end
                    ST_TWO: begin
                        // Ready was low, so no push can arrive here.
                        if (pop) begin
                            state_reg     <= ST_ONE;
                            ready_reg     <= 1'b1;
                            main_data_reg <= skid_data_reg;
                            main_ctrl_reg <= skid_ctrl_reg;
                            skid_data_reg <= '0;
                            skid_ctrl_reg <= '0;
                        end
                    end
                    default: begin
                        state_reg <= ST_EMPTY;
                        ready_reg <= 1'b1;
                    end
                endcase
            end
        end

        assign stage_valid[gi] = (state_reg != ST_EMPTY);
        assign stage_ready[gi] = ready_reg;
        assign stage_data[gi]  = main_data_reg;
        assign stage_ctrl[gi]  = main_ctrl_reg;
    end

    assign in_ready  = stage_ready[0] & ~hold;
    assign out_valid = stage_valid[DEPTH-1] & ~hold;
    assign out_data  = stage_data[DEPTH-1];
    assign out_ctrl  = out_valid ? stage_ctrl[DEPTH-1] : '0;

    logic               in_xfer;
    logic               out_xfer;
    logic [COUNT_W-1:0] count_reg;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            count_reg <= '0;
        end else if (flush) begin
            count_reg <= '0;
        end else if (!hold) begin
            count_reg <= count_reg + COUNT_W'(in_xfer) - COUNT_W'(out_xfer);
        end
    end

    assign count = count_reg;

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Drives DEPTH=1..4 instances with shared stimulus; each is checked against a queue-of-stages
// occupancy model, plus a vector table and directed multi-cycle sequences.
module tb_pipe_reg_elastic;

    localparam int NI = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic [15:0] in_ctrl;
    logic        hold;
    logic        flush;
    logic        out_ready;

    logic [NI-1:0] ir_o;
    logic [NI-1:0] ov_o;
    logic [31:0]   od_o  [NI];
    logic [15:0]   oc_o  [NI];
    logic [3:0]    cnt_o [NI];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int D = gi + 1;
        logic [$clog2(2*D+1)-1:0] cnt;
        pipe_reg_elastic #(.DATA_W(32), .CTRL_W(16), .DEPTH(D)) u_dut (
            .Clk       (clk),
            .Reset     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (ir_o[gi]),
            .in_data   (in_data),
            .in_ctrl   (in_ctrl),
            .hold      (hold),
            .flush     (flush),
            .out_valid (ov_o[gi]),
            .out_ready (out_ready),
            .out_data  (od_o[gi]),
            .out_ctrl  (oc_o[gi]),
            .count     (cnt)
        );
        assign cnt_o[gi] = 4'(cnt);
    end

    // Model: each stage is a small FIFO of at most two beats, index 0 is the oldest.
    logic [31:0] md [NI][4][2];
    logic [15:0] mc [NI][4][2];
    int          mn [NI][4];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic [15:0] c;
        logic        h;
        logic        f;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_od;
        logic [15:0] e_oc;
        int          e_cnt;
    } vec_t;

    vec_t        tbl [$];
    logic [31:0] got_q [$];

    task automatic chk(input string name, input int inst, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (DEPTH=%0d) t=%0t: got 0x%0h, expected 0x%0h", name, inst + 1, $time, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NI; i++)
            for (int k = 0; k < 4; k++)
                mn[i][k] = 0;
    endtask

    task automatic model_edge();
        int          dep;
        bit          pop [4];
        bit          room;
        bit          push0;
        logic [31:0] d;
        logic [15:0] c;
        for (int i = 0; i < NI; i++) begin
            dep = i + 1;
            if (flush) begin
                for (int k = 0; k < 4; k++) mn[i][k] = 0;
            end else if (!hold) begin
                for (int k = 0; k < dep; k++) begin
                    if (k == dep - 1) room = out_ready;
                    else              room = (mn[i][k+1] < 2);
                    pop[k] = (mn[i][k] > 0) && room;
                end
                push0 = in_valid && (mn[i][0] < 2);
                for (int k = dep - 1; k >= 0; k--) begin
                    if (pop[k]) begin
                        d = md[i][k][0];
                        c = mc[i][k][0];
                        md[i][k][0] = md[i][k][1];
                        mc[i][k][0] = mc[i][k][1];
                        mn[i][k]--;
                        if (k < dep - 1) begin
                            md[i][k+1][mn[i][k+1]] = d;
                            mc[i][k+1][mn[i][k+1]] = c;
                            mn[i][k+1]++;
                        end
                    end
                end
                if (push0) begin
                    md[i][0][mn[i][0]] = in_data;
                    mc[i][0][mn[i][0]] = in_ctrl;
                    mn[i][0]++;
                end
            end
        end
    endtask

    task automatic model_check_all();
        int   dep;
        int   occ;
        logic eov;
        logic eir;
        for (int i = 0; i < NI; i++) begin
            dep = i + 1;
            occ = 0;
            for (int k = 0; k < dep; k++) occ += mn[i][k];
            eov = !hold && (mn[i][dep-1] > 0);
            eir = !hold && (mn[i][0] < 2);
            chk("model_in_ready", i, 32'(ir_o[i]), 32'(eir));
            chk("model_out_valid", i, 32'(ov_o[i]), 32'(eov));
            chk("model_out_ctrl", i, 32'(oc_o[i]), eov ? 32'(mc[i][dep-1][0]) : 32'd0);
            if (eov) chk("model_out_data", i, od_o[i], md[i][dep-1][0]);
            chk("model_count", i, 32'(cnt_o[i]), 32'(occ));
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] d, input logic [15:0] c,
                         input logic h, input logic f, input logic ordy);
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        hold      = h;
        flush     = f;
        out_ready = ordy;
    endtask

    task automatic settle();
        @(negedge clk);
        model_check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_flush();
        drive(1'b0, 32'h0, 16'h0, 1'b0, 1'b1, 1'b0);
        settle();
        tick();
    endtask

    task automatic add_vec(input logic iv, input logic [31:0] d, input logic [15:0] c,
                           input logic h, input logic f, input logic ordy,
                           input logic e_ir, input logic e_ov, input logic [31:0] e_od,
                           input logic [15:0] e_oc, input int e_cnt);
        vec_t v;
        v.iv = iv; v.d = d; v.c = c; v.h = h; v.f = f; v.ordy = ordy;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_oc = e_oc; v.e_cnt = e_cnt;
        tbl.push_back(v);
    endtask

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < NI; i++) begin
            chk({tag, "_in_ready"}, i, 32'(ir_o[i]), 32'd1);
            chk({tag, "_out_valid"}, i, 32'(ov_o[i]), 32'd0);
            chk({tag, "_out_data"}, i, od_o[i], 32'd0);
            chk({tag, "_out_ctrl"}, i, 32'(oc_o[i]), 32'd0);
            chk({tag, "_count"}, i, 32'(cnt_o[i]), 32'd0);
        end
    endtask

    initial begin
        // DEPTH=1 vectors: outputs expected before the edge on which the inputs are applied.
        //       iv    data      ctrl    h     f     ordy   ir    ov    od        oc      cnt
        add_vec(1'b1, 32'h11, 16'h1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,  16'h0, 0);
        add_vec(1'b1, 32'h22, 16'h2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11, 16'h1, 1);
        add_vec(1'b1, 32'h33, 16'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h11, 16'h1, 2);
        add_vec(1'b0, 32'h0,  16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h11, 16'h1, 2);
        add_vec(1'b0, 32'h0,  16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h22, 16'h2, 1);
        add_vec(1'b1, 32'h44, 16'h4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  16'h0, 0);
        add_vec(1'b1, 32'h55, 16'h5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h44, 16'h4, 1);
        add_vec(1'b1, 32'h66, 16'h6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  16'h0, 1);
        add_vec(1'b1, 32'h66, 16'h6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h55, 16'h5, 1);
        add_vec(1'b1, 32'h77, 16'h7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  16'h0, 2);
        add_vec(1'b0, 32'h0,  16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,  16'h0, 0);

        rst_n = 1'b1;
        drive(1'b0, 32'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        model_clear();
        #2 rst_n = 1'b0;
        #1 check_reset_state("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Vector table on DEPTH=1
        foreach (tbl[n]) begin
            drive(tbl[n].iv, tbl[n].d, tbl[n].c, tbl[n].h, tbl[n].f, tbl[n].ordy);
            settle();
            chk("vec_in_ready", 0, 32'(ir_o[0]), 32'(tbl[n].e_ir));
            chk("vec_out_valid", 0, 32'(ov_o[0]), 32'(tbl[n].e_ov));
            chk("vec_out_ctrl", 0, 32'(oc_o[0]), 32'(tbl[n].e_oc));
            if (tbl[n].e_ov) chk("vec_out_data", 0, od_o[0], tbl[n].e_od);
            chk("vec_count", 0, 32'(cnt_o[0]), 32'(tbl[n].e_cnt));
            $display("vec %0d: iv=%0b d=0x%0h h=%0b f=%0b ordy=%0b -> ov=%0b od=0x%0h cnt=%0d",
                     n, tbl[n].iv, tbl[n].d, tbl[n].h, tbl[n].f, tbl[n].ordy, ov_o[0], od_o[0], cnt_o[0]);
            tick();
        end

        // Latency on DEPTH=2
        do_flush();
        drive(1'b1, 32'hA5A5_0001, 16'h0003, 1'b0, 1'b0, 1'b1);
        settle(); chk("lat_c0_count", 1, 32'(cnt_o[1]), 32'd0); tick();
        drive(1'b0, 32'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        settle();
        chk("lat_c1_count", 1, 32'(cnt_o[1]), 32'd1);
        chk("lat_c1_out_valid", 1, 32'(ov_o[1]), 32'd0);
        tick();
        settle();
        chk("lat_c2_out_valid", 1, 32'(ov_o[1]), 32'd1);
        chk("lat_c2_out_data", 1, od_o[1], 32'hA5A5_0001);
        chk("lat_c2_out_ctrl", 1, 32'(oc_o[1]), 32'h3);
        chk("lat_c2_count", 1, 32'(cnt_o[1]), 32'd1);
        tick();
        settle(); chk("lat_c3_out_valid", 1, 32'(ov_o[1]), 32'd0); tick();
        $display("latency sequence done");

        // Hold on DEPTH=2 with a four-beat stream
        do_flush();
        got_q.delete();
        for (int c = 0; c < 16; c++) begin
            case (c)
                0:       drive(1'b1, 32'hB000_0000, 16'h10, 1'b0, 1'b0, 1'b1);
                1:       drive(1'b1, 32'hB000_0001, 16'h11, 1'b0, 1'b0, 1'b1);
                2, 3, 4: drive(1'b1, 32'hB000_0002, 16'h12, 1'b1, 1'b0, 1'b1);
                5:       drive(1'b1, 32'hB000_0002, 16'h12, 1'b0, 1'b0, 1'b1);
                6:       drive(1'b1, 32'hB000_0003, 16'h13, 1'b0, 1'b0, 1'b1);
                default: drive(1'b0, 32'h0, 16'h0, 1'b0, 1'b0, 1'b1);
            endcase
            settle();
            if (c >= 2 && c <= 4) begin
                chk("hold_out_valid", 1, 32'(ov_o[1]), 32'd0);
                chk("hold_in_ready", 1, 32'(ir_o[1]), 32'd0);
                chk("hold_count", 1, 32'(cnt_o[1]), 32'd2);
            end
            if (ov_o[1] && out_ready) got_q.push_back(od_o[1]);
            tick();
        end
        chk("hold_beats_out", 1, 32'(got_q.size()), 32'd4);
        for (int b = 0; b < 4 && b < got_q.size(); b++)
            chk("hold_beat_order", 1, got_q[b], 32'hB000_0000 + 32'(b));
        $display("hold sequence done: %0d beats out", got_q.size());

        // Flush with hold and in_valid in the same cycle, DEPTH=2 holding three beats
        do_flush();
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 32'hC000_0000 + 32'(c), 16'h20, 1'b0, 1'b0, 1'b0);
            settle(); tick();
        end
        drive(1'b1, 32'hDEAD_BEEF, 16'hBEEF, 1'b1, 1'b1, 1'b0);
        settle(); chk("flush_pre_count", 1, 32'(cnt_o[1]), 32'd3); tick();
        drive(1'b0, 32'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        settle();
        chk("flush_count", 1, 32'(cnt_o[1]), 32'd0);
        chk("flush_out_ctrl", 1, 32'(oc_o[1]), 32'd0);
        chk("flush_in_ready", 1, 32'(ir_o[1]), 32'd1);
        tick();
        for (int c = 0; c < 5; c++) begin
            settle(); chk("flush_no_ghost", 1, 32'(ov_o[1]), 32'd0); tick();
        end
        $display("flush sequence done");

        // Fill DEPTH=4, then assert Reset between edges
        do_flush();
        for (int c = 0; c < 16; c++) begin
            drive(1'b1, 32'hE000_0000 + 32'(c), 16'(c + 1), 1'b0, 1'b0, 1'b0);
            settle(); tick();
        end
        drive(1'b0, 32'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("full_count", 3, 32'(cnt_o[3]), 32'd8);
        chk("full_in_ready", 3, 32'(ir_o[3]), 32'd0);
        tick();
        #2 rst_n = 1'b0;
        #1 check_reset_state("async_reset");
        model_clear();
        rst_n = 1'b1;
        $display("async reset sequence done");

        // Random stress on all depths
        for (int c = 0; c < 10000; c++) begin
            drive($urandom_range(0, 99) < 70, $urandom, 16'($urandom),
                  $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 2,
                  $urandom_range(0, 99) < 65);
            settle();
            tick();
        end
        $display("random stress done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
